// File: rtl/glb_pol_rd_port.sv
// GLB-side read responder for one pooling-core port: credit-gated address accept,
// fixed 1-cycle SRAM read, in-order return FIFO with valid/ready Ofm output.
module glb_pol_rd_port #(
  parameter int IDX_WIDTH      = 10,
  parameter int ACT_WIDTH      = 8,
  parameter int POOL_COMP_CORE = 64,
  parameter int FIFO_DEPTH     = 4,
  localparam int W             = ACT_WIDTH * POOL_COMP_CORE,
  localparam int PTR_W         = $clog2(FIFO_DEPTH),
  localparam int OCC_W         = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MIFGLB_Rst,
  input  logic                 MIFGLB_AddrVld,
  input  logic [IDX_WIDTH-1:0] MIFGLB_Addr,
  output logic                 GLBMIF_AddrRdy,
  output logic                 GLB_RdEn,
  output logic [IDX_WIDTH-1:0] GLB_RdAddr,
  input  logic [W-1:0]         GLB_RdDat,
  output logic [W-1:0]         GLBMIF_Ofm,
  output logic                 GLBMIF_OfmVld,
  input  logic                 MIFGLB_OfmRdy,
  output logic [15:0]          GLBMIF_RdCnt
);

  logic             clr;
  logic             acc;
  logic             wr;
  logic             pop;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pend_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [15:0]      rd_cnt_q;
  logic [OCC_W:0]   credit_used;
  logic [W-1:0]     mem [FIFO_DEPTH];

  assign clr = rst | MIFGLB_Rst;

  // Credits cover both buffered words and the read still in flight, so the
  // FIFO can never be overrun even though the ready path ignores OfmRdy.
  assign credit_used    = {1'b0, occ_q} + {{OCC_W{1'b0}}, pend_q};
  assign GLBMIF_AddrRdy = !clr && (credit_used < (OCC_W+1)'(FIFO_DEPTH));

  assign acc        = MIFGLB_AddrVld & GLBMIF_AddrRdy;
  assign GLB_RdEn   = acc;
  assign GLB_RdAddr = MIFGLB_Addr;

  assign wr  = pend_q;
  assign pop = GLBMIF_OfmVld & MIFGLB_OfmRdy;

  assign GLBMIF_OfmVld = !clr && (occ_q != '0);
  assign GLBMIF_Ofm    = mem[rd_ptr_q];
  assign GLBMIF_RdCnt  = rd_cnt_q;

  always_comb begin
    occ_d = occ_q;
    case ({wr, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      occ_q    <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= acc;
      if (wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  // Storage is never cleared; a read landing during clear is simply not written.
  always_ff @(posedge clk) begin
    if (wr && !clr) begin
      mem[wr_ptr_q] <= GLB_RdDat;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (clr)
    !(wr && !pop && (occ_q == OCC_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_glb_pol_rd_port.sv
// Self-checking bench for glb_pol_rd_port: reset/single-read vector table, directed
// streaming/backpressure/soft-clear/wrap sequences and a randomized phase vs a queue model.
module tb_glb_pol_rd_port;
  localparam int IDX   = 10;
  localparam int ACT   = 8;
  localparam int PCC   = 64;
  localparam int DEPTH = 4;
  localparam int W     = ACT * PCC;

  logic           clk = 1'b0;
  logic           rst;
  logic           MIFGLB_Rst;
  logic           MIFGLB_AddrVld;
  logic [IDX-1:0] MIFGLB_Addr;
  logic           GLBMIF_AddrRdy;
  logic           GLB_RdEn;
  logic [IDX-1:0] GLB_RdAddr;
  logic [W-1:0]   GLB_RdDat;
  logic [W-1:0]   GLBMIF_Ofm;
  logic           GLBMIF_OfmVld;
  logic           MIFGLB_OfmRdy;
  logic [15:0]    GLBMIF_RdCnt;

  glb_pol_rd_port #(
    .IDX_WIDTH(IDX), .ACT_WIDTH(ACT), .POOL_COMP_CORE(PCC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .MIFGLB_Rst(MIFGLB_Rst),
    .MIFGLB_AddrVld(MIFGLB_AddrVld), .MIFGLB_Addr(MIFGLB_Addr),
    .GLBMIF_AddrRdy(GLBMIF_AddrRdy), .GLB_RdEn(GLB_RdEn), .GLB_RdAddr(GLB_RdAddr),
    .GLB_RdDat(GLB_RdDat), .GLBMIF_Ofm(GLBMIF_Ofm), .GLBMIF_OfmVld(GLBMIF_OfmVld),
    .MIFGLB_OfmRdy(MIFGLB_OfmRdy), .GLBMIF_RdCnt(GLBMIF_RdCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input logic [IDX-1:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < W/16; i++) w[i*16 +: 16] = {6'(i), a};
    return w;
  endfunction

  function automatic logic [W-1:0] noise();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // SRAM: data for an enabled read appears one cycle later, garbage otherwise.
  always @(posedge clk) begin
    if (GLB_RdEn) GLB_RdDat <= word_of(GLB_RdAddr);
    else          GLB_RdDat <= noise();
  end

  // Reference model: the queue holds accepted-but-unreturned requests in order.
  typedef struct {
    logic [IDX-1:0] addr;
    int             cyc;
  } req_t;
  req_t        q[$];
  int          cyc;
  logic [15:0] m_cnt;

  int checks = 0;
  int errors = 0;
  int dut_acc;

  logic        obs_rdy, obs_rden, obs_vld;
  logic [15:0] obs_cnt;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic [IDX-1:0] a,
                      input logic o, input bit chk);
    logic e_rdy, e_vld, e_rden, clr;
    rst = r; MIFGLB_Rst = s; MIFGLB_AddrVld = v; MIFGLB_Addr = a; MIFGLB_OfmRdy = o;
    clr    = r | s;
    e_rdy  = !clr && (q.size() < DEPTH);
    e_vld  = !clr && (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    e_rden = v && e_rdy;
    @(negedge clk);
    obs_rdy = GLBMIF_AddrRdy; obs_rden = GLB_RdEn; obs_vld = GLBMIF_OfmVld; obs_cnt = GLBMIF_RdCnt;
    if (chk) begin
      check("addr_rdy", W'(GLBMIF_AddrRdy), W'(e_rdy));
      check("rd_en", W'(GLB_RdEn), W'(e_rden));
      if (e_rden) check("rd_addr", W'(GLB_RdAddr), W'(a));
      check("ofm_vld", W'(GLBMIF_OfmVld), W'(e_vld));
      if (e_vld) check("ofm", GLBMIF_Ofm, word_of(q[0].addr));
      check("rd_cnt", W'(GLBMIF_RdCnt), W'(m_cnt));
      if (GLBMIF_OfmVld && o)
        $display("xfer cyc=%0d word_lsb=%04h rdcnt=%0d", cyc, GLBMIF_Ofm[15:0], GLBMIF_RdCnt);
    end
    if (GLBMIF_AddrRdy && v) dut_acc++;
    @(posedge clk);
    cyc++;
    if (clr) begin
      q.delete();
      m_cnt = 16'd0;
    end else begin
      if (e_vld && o) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (e_rden) q.push_back('{addr: a, cyc: cyc - 1});
    end
    #1;
  endtask

  typedef struct {
    bit             r, s, v;
    logic [IDX-1:0] a;
    bit             o;
    bit             e_rdy, e_rden, e_vld;
    logic [15:0]    e_cnt;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [15:0] base;
    int          guard;
    tbl[0] = '{1, 0, 1, 10'h005, 1, 0, 0, 0, 16'd0};
    tbl[1] = '{1, 0, 1, 10'h005, 1, 0, 0, 0, 16'd0};
    tbl[2] = '{0, 0, 0, 10'h000, 1, 1, 0, 0, 16'd0};
    tbl[3] = '{0, 0, 1, 10'h005, 1, 1, 1, 0, 16'd0};
    tbl[4] = '{0, 0, 0, 10'h000, 1, 1, 0, 0, 16'd0};
    tbl[5] = '{0, 0, 0, 10'h000, 1, 1, 0, 1, 16'd0};
    tbl[6] = '{0, 0, 0, 10'h000, 1, 1, 0, 0, 16'd1};

    cyc = 0; m_cnt = 16'd0; dut_acc = 0;
    rst = 1'b1; MIFGLB_Rst = 1'b0; MIFGLB_AddrVld = 1'b0; MIFGLB_Addr = '0; MIFGLB_OfmRdy = 1'b0;
    @(posedge clk); #1;

    // Reset and single read
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].a, tbl[i].o, 1);
      check("tbl_rdy", W'(obs_rdy), W'(tbl[i].e_rdy));
      check("tbl_rden", W'(obs_rden), W'(tbl[i].e_rden));
      check("tbl_vld", W'(obs_vld), W'(tbl[i].e_vld));
      check("tbl_cnt", W'(obs_cnt), W'(tbl[i].e_cnt));
    end

    // Streaming 0..15 back-to-back
    base = GLBMIF_RdCnt; dut_acc = 0;
    for (int i = 0; i < 16; i++) step(0, 0, 1, IDX'(i), 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 1);
    check("stream_accepts", W'(dut_acc), W'(16));
    check("stream_cnt", W'(GLBMIF_RdCnt - base), W'(16));

    // Backpressure: only DEPTH requests fit
    dut_acc = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, IDX'(10'h100 + dut_acc), 0, 1);
    check("bp_accepts", W'(dut_acc), W'(DEPTH));
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, 1);

    // Soft clear with 3 buffered and 1 pending
    for (int i = 0; i < 4; i++) step(0, 0, 1, IDX'(10'h200 + i), 0, 1);
    step(0, 1, 1, 10'h3FF, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 1);
    check("clr_cnt", W'(GLBMIF_RdCnt), W'(0));
    step(0, 0, 1, 10'h02A, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(99) == 0, $urandom_range(9) < 7, IDX'($urandom), $urandom_range(9) < 6, 1);

    // Counter wrap
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(0, 0, 1, IDX'($urandom), 1, 0);
      guard++;
    end
    check("wrap_reach", W'(guard < 70000), W'(1));
    step(0, 0, 0, '0, 0, 1);
    check("wrap_pre", W'(obs_cnt), W'(16'hFFFF));
    step(0, 0, 0, '0, 1, 1);
    @(negedge clk);
    check("wrap_post", W'(GLBMIF_RdCnt), W'(16'h0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
